// File: rtl/cr_xer_file_pkg.sv
// Shared widths, bit indices and helpers for the XER/CR state holder.
// Field/bit numbering is big-endian: bit 0 is the MSB.
package cr_xer_file_pkg;

  localparam int XER_WIDTH = 32;
  localparam int CR_WIDTH  = 32;
  localparam int CR0_WIDTH = 4;
  localparam int CR_FIELDS = 8;
  localparam int FXM_WIDTH = CR_FIELDS;

  localparam int XER_SO = 0;
  localparam int XER_OV = 1;
  localparam int XER_CA = 2;

  typedef logic [0:XER_WIDTH-1] xer_t;
  typedef logic [0:CR_WIDTH-1]  cr_t;
  typedef logic [0:FXM_WIDTH-1] fxm_t;
  typedef logic [0:CR0_WIDTH-1] crf_t;

  typedef struct packed {
    logic xer_v;
    logic cr_v;
    xer_t xer;
    cr_t  cr;
  } inflight_t;

  function automatic cr_t cr_merge(
    input cr_t base,
    input cr_t wd,
    input cr_t mask
  );
    return (base & ~mask) | (wd & mask);
  endfunction

  function automatic crf_t cr_field(
    input cr_t cr,
    input int  idx
  );
    return cr[CR0_WIDTH*idx +: CR0_WIDTH];
  endfunction

  function automatic logic xer_so(input xer_t x);
    return x[XER_SO];
  endfunction

endpackage

// File: rtl/cr_xer_file_if.sv
// Flag-output stage <-> XER/CR file bundle.
// master: flag-output stage, slave: cr_xer_file.
interface cr_xer_if;
  import cr_xer_file_pkg::*;

  logic stall;
  logic flush;
  logic xer_we;
  xer_t xer_wd;
  logic cr_we;
  cr_t  cr_wd;
  fxm_t cr_fxm;
  xer_t XERrd;
  cr_t  CRrd;
  xer_t xer_arch;
  cr_t  cr_arch;
  logic hazard;

  modport master (
    output stall, flush,
    output xer_we, xer_wd,
    output cr_we, cr_wd, cr_fxm,
    input  XERrd, CRrd,
    input  xer_arch, cr_arch,
    input  hazard
  );

  modport slave (
    input  stall, flush,
    input  xer_we, xer_wd,
    input  cr_we, cr_wd, cr_fxm,
    output XERrd, CRrd,
    output xer_arch, cr_arch,
    output hazard
  );

endinterface

// File: rtl/cr_fxm_expand.sv
// Expands an 8-bit mtcrf field mask to a 32-bit CR bit mask.
// fxm bit i covers CR[4i:4i+3].
module cr_fxm_expand
  import cr_xer_file_pkg::*;
(
  input  fxm_t fxm_i,
  output cr_t  mask_o
);

  for (genvar i = 0; i < CR_FIELDS; i++) begin : g_fld
    assign mask_o[CR0_WIDTH*i +: CR0_WIDTH] = {CR0_WIDTH{fxm_i[i]}};
  end

endmodule

// File: rtl/cr_xer_file.sv
// XER/CR architectural state with a one-deep in-flight entry.
// CR_XER_BYPASS_EN: forward the in-flight entry; else expose hazard.
module cr_xer_file
  import cr_xer_file_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  cr_xer_if.slave bus
);

  inflight_t p_q, p_d;
  xer_t      arch_xer_q, arch_xer_d;
  cr_t       arch_cr_q, arch_cr_d;

  cr_t  fxm_mask;
  cr_t  cr_base;
  xer_t xer_view;
  cr_t  cr_view;
  logic hazard;

  cr_fxm_expand u_fxm (
    .fxm_i  (bus.cr_fxm),
    .mask_o (fxm_mask)
  );

`ifdef CR_XER_BYPASS_EN
  // Views depend only on registers: no loop back into the flag stage.
  assign xer_view = p_q.xer_v ? p_q.xer : arch_xer_q;
  assign cr_view  = p_q.cr_v  ? p_q.cr  : arch_cr_q;
  assign cr_base  = cr_view;
  assign hazard   = 1'b0;
`else
  assign xer_view = arch_xer_q;
  assign cr_view  = arch_cr_q;
  assign cr_base  = arch_cr_q;
  assign hazard   = p_q.xer_v | p_q.cr_v;
`endif

  always_comb begin
    p_d        = p_q;
    arch_xer_d = arch_xer_q;
    arch_cr_d  = arch_cr_q;

    if (!bus.stall) begin
      if (p_q.xer_v) arch_xer_d = p_q.xer;
      if (p_q.cr_v)  arch_cr_d  = p_q.cr;
    end

    // flush kills valids even under stall; data is don't-care.
    if (bus.flush) begin
      p_d.xer_v = 1'b0;
      p_d.cr_v  = 1'b0;
    end else if (!bus.stall) begin
      p_d.xer_v = bus.xer_we;
      p_d.xer   = bus.xer_wd;
      p_d.cr_v  = bus.cr_we;
      p_d.cr    = cr_merge(cr_base, bus.cr_wd, fxm_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= '0;
      arch_xer_q <= '0;
      arch_cr_q  <= '0;
    end else begin
      p_q        <= p_d;
      arch_xer_q <= arch_xer_d;
      arch_cr_q  <= arch_cr_d;
    end
  end

  assign bus.XERrd    = xer_view;
  assign bus.CRrd     = cr_view;
  assign bus.xer_arch = arch_xer_q;
  assign bus.cr_arch  = arch_cr_q;
  assign bus.hazard   = hazard;

endmodule
